// File: rtl/jk_cnt_pkg.sv
// Shared types for the JK-flip-flop counter sequencer: run-control states and per-bit J/K actions.
package jk_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        JK_HOLD  = 2'd0,
        JK_COUNT = 2'd1,
        JK_CLEAR = 2'd2
    } jk_op_t;

    function automatic logic is_busy(input seq_state_t s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_ff (
    input  logic clk,
    input  logic reset,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_counter_sequencer.sv
// Run-control sequencer driving a WIDTH-bit JK-flip-flop up counter (one-shot / auto-reload).
// Optional tick prescaler is enabled by defining JKSEQ_PRESCALE_EN.
module jk_counter_sequencer
    import jk_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               mode_reload,
    input  logic [WIDTH-1:0]   term,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               paused,
    output logic               tc,
    output logic               done
);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    jk_op_t           w_op;
    logic [WIDTH-1:0] r_term;
    logic             r_reload;
    logic             r_tc;
    logic             r_done;
    logic             w_start_ok;
    logic             w_active;
    logic             w_tick;
    logic             w_at_term;
    logic             w_wrap;
    logic             w_finish;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    // A busy cycle with pause low is a live cycle; this keeps pause/resume tick-exact.
    assign w_active   = is_busy(r_state) && !pause;
    assign w_at_term  = (count == r_term);
    assign w_wrap     = w_tick && w_at_term && r_reload;
    assign w_finish   = w_tick && w_at_term && !r_reload;

`ifdef JKSEQ_PRESCALE_EN
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_presc_cnt <= '0;
        end else if (stop) begin
            r_presc_cnt <= '0;
        end else if (w_start_ok) begin
            r_presc     <= presc;
            r_presc_cnt <= '0;
        end else if (w_active) begin
            r_presc_cnt <= (r_presc_cnt == r_presc) ? '0 : r_presc_cnt + 1'b1;
        end
    end

    assign w_tick = w_active && (r_presc_cnt == r_presc);
`else
    logic w_unused_presc;
    assign w_unused_presc = ^presc;
    assign w_tick         = w_active;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_term   <= '0;
            r_reload <= 1'b0;
        end else if (!stop && w_start_ok) begin
            r_term   <= term;
            r_reload <= mode_reload;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = IDLE;
        end else if (w_start_ok) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (pause) begin
                        w_state_next = PAUSE;
                    end else if (w_finish) begin
                        w_state_next = DONE;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        w_state_next = w_finish ? DONE : RUN;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy   = is_busy(r_state);
        paused = (r_state == PAUSE);
        tc     = r_tc;
        done   = r_done;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tc   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tc   <= !stop && w_wrap;
            r_done <= !stop && w_finish;
        end
    end

    always_comb begin
        w_op = JK_HOLD;
        if (stop || w_start_ok || w_wrap) begin
            w_op = JK_CLEAR;
        end else if (w_tick && !w_at_term) begin
            w_op = JK_COUNT;
        end
    end

    // Bit i toggles only when every lower bit is 1.
    always_comb begin
        w_carry = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_carry[i] = &(count | ~((WIDTH'(1) << i) - WIDTH'(1)));
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        case (w_op)
            JK_COUNT: begin
                w_j = {WIDTH{w_tick}} & w_carry;
                w_k = {WIDTH{w_tick}} & w_carry;
            end
            JK_CLEAR: begin
                w_j = '0;
                w_k = '1;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        jk_ff u_ff (
            .clk   (clk),
            .reset (reset),
            .i_j   (w_j[gi]),
            .i_k   (w_k[gi]),
            .o_q   (count[gi])
        );
    end

endmodule
